// File: rtl/mips_pkg.sv
// Shared widths, defaults and bundle types for the MIPS core.
// Imported by the writeback arbiter and its result FIFO.
package mips_pkg;

  localparam int DATA_W         = 32;
  localparam int REG_AW         = 5;
  localparam int MD_DEPTH       = 2;
  localparam int MD_STARVE_MAX  = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rn;
    logic [DATA_W-1:0] data;
  } md_ent_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order mul/div result buffer: push/pop, full/empty, head entry,
// per-entry valid bits and destination registers for hazard decode.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = MD_DEPTH
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic                         push,
  input  logic                         pop,
  input  md_ent_t                      din,
  output logic                         full,
  output logic                         empty,
  output md_ent_t                      head,
  output logic [DEPTH-1:0]             vld,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_rn
);

  localparam int AW = $clog2(DEPTH);

  md_ent_t        mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rp];

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ent_rn[i] = mem[i].rn;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // pop never targets a free slot and push never a live one,
      // so the clear and set below cannot collide.
      if (pop)  vld[rp] <= 1'b0;
      if (push) vld[wp] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single RF write port between the WB stage and buffered
// mul/div results, forcing a buffer drain after STARVE_MAX pipe wins.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH      = MD_DEPTH,
  parameter int STARVE_MAX = MD_STARVE_MAX
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              wwreg,
  input  logic [REG_AW-1:0] wrn,
  input  logic [DATA_W-1:0] wdata,
  input  logic              md_valid,
  input  logic [REG_AW-1:0] md_rn,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wn,
  output logic [DATA_W-1:0] rf_d,
  output logic              stall,
  output logic [DATA_W-1:0] md_pending
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                         full;
  logic                         empty;
  logic                         push;
  logic                         pop;
  md_ent_t                      head;
  md_ent_t                      din;
  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rn;
  logic [SW-1:0]                starve_cnt;
  logic                         force_drain;
  logic                         pipe_req;
  logic                         sel_head;
  logic                         sel_pipe;

  assign md_ready = !full;
  // r0 results are acknowledged but never stored.
  assign push = md_valid && md_ready && (md_rn != '0);
  assign din  = '{rn: md_rn, data: md_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .clrn   (clrn),
    .push   (push),
    .pop    (pop),
    .din    (din),
    .full   (full),
    .empty  (empty),
    .head   (head),
    .vld    (vld),
    .ent_rn (ent_rn)
  );

  assign force_drain = (starve_cnt == SW'(STARVE_MAX)) && !empty;
  assign stall       = force_drain;
  assign pipe_req    = wwreg && (wrn != '0);
  assign sel_head    = force_drain || (!pipe_req && !empty);
  assign sel_pipe    = pipe_req && !force_drain;
  assign pop         = sel_head;

  always_comb begin
    rf_we = 1'b0;
    rf_wn = '0;
    rf_d  = '0;
    unique case (1'b1)
      sel_head: begin
        rf_we = 1'b1;
        rf_wn = head.rn;
        rf_d  = head.data;
      end
      sel_pipe: begin
        rf_we = 1'b1;
        rf_wn = wrn;
        rf_d  = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    md_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) md_pending[ent_rn[i]] = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      starve_cnt <= '0;
    else if (empty || pop)
      starve_cnt <= '0;
    else if (sel_pipe && starve_cnt != SW'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule
